// File: rtl/ifu_pkg.sv
// ifu_pkg - shared definitions for the instruction fetch unit.
// Holds the project-wide fetch defines (RESET_PC, NOP encoding and the
// instruction/address widths) plus the FIFO entry type. This file must be
// compiled before the other ifu files.
// Optional feature of the fetch unit: IFU_MISALIGN_TRAP_EN (see ifu.sv).
`ifndef IFU_DEFINES_DONE
`define IFU_DEFINES_DONE
`define INST_WIDTH      32
`define INST_ADDR_WIDTH 32
`define RESET_PC        32'h0000_0000
`define INST_NOP        32'h0000_0013
`endif

package ifu_pkg;

  localparam int INST_W     = `INST_WIDTH;
  localparam int ADDR_W     = `INST_ADDR_WIDTH;
  localparam int ENTRY_W    = ADDR_W + INST_W;
  localparam int FIFO_DEPTH = 2;

  localparam logic [ADDR_W-1:0] RESET_PC = `RESET_PC;
  localparam logic [INST_W-1:0] NOP_INST = `INST_NOP;

  // One buffered instruction together with the address it was fetched from.
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [INST_W-1:0] inst;
  } fetch_entry_t;

  // Clears the two byte-offset bits of a redirect target.
  function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] a);
    return {a[ADDR_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/ifu_fifo.sv
// ifu_fifo - small register-based FIFO used as the fetch buffer.
// Push data becomes visible on head one cycle after the push edge; there is
// no bypass from push_data to head. flush empties the FIFO and overrides a
// coincident push or pop.
module ifu_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic [WIDTH-1:0]             push_data,
  input  logic                         pop,
  input  logic                         flush,
  output logic [WIDTH-1:0]             head,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic             do_push;
  logic             do_pop;

  // Pointers wrap explicitly so a non-power-of-two depth also works.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full    = (count_reg == CNT_W'(DEPTH));
  assign empty   = (count_reg == '0);
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;
  assign head    = mem[rd_ptr_reg];
  assign count   = count_reg;

  // Storage write; entries need no reset because head is qualified by count.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= push_data;
    end
  end

  // Pointer and occupancy bookkeeping; flush wins over push/pop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_reg <= ptr_inc(wr_ptr_reg);
      end
      if (do_pop) begin
        rd_ptr_reg <= ptr_inc(rd_ptr_reg);
      end
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + CNT_W'(1);
        2'b01:   count_reg <= count_reg - CNT_W'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/ifu.sv
// ifu - instruction fetch unit.
// Issues sequential word fetches from a PC register, keeps at most two
// instructions in flight or buffered, discards responses made stale by a
// redirect and hands instructions to decode through a two-entry FIFO.
// Optional feature: define IFU_MISALIGN_TRAP_EN to pulse misalign_o for one
// cycle after a redirect whose target has nonzero low bits; otherwise those
// bits are silently cleared and misalign_o stays 0.
module ifu
  import ifu_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              jump_en_i,
  input  logic [ADDR_W-1:0] jump_addr_i,
  input  logic              hold_i,
  output logic              rom_req_o,
  output logic [ADDR_W-1:0] rom_addr_o,
  input  logic              rom_gnt_i,
  input  logic              rom_rvalid_i,
  input  logic [INST_W-1:0] rom_rdata_i,
  output logic [INST_W-1:0] inst_o,
  output logic [ADDR_W-1:0] inst_addr_o,
  output logic              inst_valid_o,
  output logic              misalign_o
);

  logic [ADDR_W-1:0]  pc_reg;
  logic [ADDR_W-1:0]  pc_next;
  logic [1:0]         outstanding_reg;
  logic [1:0]         outstanding_next;
  logic [1:0]         discard_reg;
  logic [1:0]         discard_next;
  logic               misalign_reg;

  logic [1:0]         fifo_count;
  logic               fifo_full;
  logic               fifo_empty;
  logic [ENTRY_W-1:0] fifo_head_raw;
  fetch_entry_t       fifo_head;
  fetch_entry_t       fifo_push_entry;

  logic [2:0]         in_use;
  logic               has_credit;
  logic               grant;
  logic               resp_live;
  logic               resp_stale;
  logic               push;
  logic               pop;
  logic [1:0]         live_count;
  logic [ADDR_W-1:0]  resp_addr;
  logic [ADDR_W-1:0]  jump_target;

  // Credit: buffered plus in-flight instructions may not exceed the FIFO depth,
  // so a response always finds room. Requests are also masked during reset.
  assign in_use     = {1'b0, fifo_count} + {1'b0, outstanding_reg};
  assign has_credit = (in_use < 3'(FIFO_DEPTH));
  assign rom_req_o  = rst && has_credit && !jump_en_i;
  assign rom_addr_o = pc_reg;
  assign grant      = rom_req_o && rom_gnt_i;

  // A response with nothing outstanding is a leftover from before reset and
  // is ignored; responses still covered by the discard count are stale.
  assign resp_live  = rom_rvalid_i && (outstanding_reg != 2'd0);
  assign resp_stale = resp_live && (discard_reg != 2'd0);

  // Responses are in order and addresses are sequential, so the oldest live
  // request was issued live_count words before the current PC.
  assign live_count = outstanding_reg - discard_reg;
  assign resp_addr  = pc_reg - ADDR_W'({live_count, 2'b00});

  assign jump_target = word_align(jump_addr_i);

  // A redirect wins over a response push and over a pop.
  assign push = resp_live && !resp_stale && !jump_en_i && !fifo_full;
  assign pop  = !fifo_empty && !hold_i && !jump_en_i;

  assign fifo_push_entry = '{addr: resp_addr, inst: rom_rdata_i};
  assign fifo_head       = fifo_head_raw;

  ifu_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (fifo_push_entry),
    .pop       (pop),
    .flush     (jump_en_i),
    .head      (fifo_head_raw),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Decode sees the FIFO head, or a NOP at the current PC when nothing is buffered.
  assign inst_valid_o = !fifo_empty;
  assign inst_o       = fifo_empty ? NOP_INST : fifo_head.inst;
  assign inst_addr_o  = fifo_empty ? pc_reg : fifo_head.addr;
  assign misalign_o   = misalign_reg;

  // Next-state for PC, outstanding and discard counters.
  always_comb begin
    pc_next          = pc_reg;
    outstanding_next = outstanding_reg;
    discard_next     = discard_reg;
    if (grant && !resp_live) begin
      outstanding_next = outstanding_reg + 2'd1;
    end else if (!grant && resp_live) begin
      outstanding_next = outstanding_reg - 2'd1;
    end
    if (jump_en_i) begin
      // Everything still in flight after this edge belongs to the old path.
      pc_next      = jump_target;
      discard_next = outstanding_next;
    end else begin
      if (grant) begin
        pc_next = pc_reg + ADDR_W'(4);
      end
      if (resp_stale) begin
        discard_next = discard_reg - 2'd1;
      end
    end
  end

  // Fetch state registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_reg          <= RESET_PC;
      outstanding_reg <= 2'd0;
      discard_reg     <= 2'd0;
    end else begin
      pc_reg          <= pc_next;
      outstanding_reg <= outstanding_next;
      discard_reg     <= discard_next;
    end
  end

`ifdef IFU_MISALIGN_TRAP_EN
  // One-cycle flag following a redirect to a non-word-aligned target.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      misalign_reg <= 1'b0;
    end else begin
      misalign_reg <= jump_en_i && (jump_addr_i[1:0] != 2'b00);
    end
  end
`else
  logic unused_jump_low;
  assign unused_jump_low = ^jump_addr_i[1:0];
  assign misalign_reg    = 1'b0;
`endif

endmodule

// File: tb/tb_ifu.sv
// tb_ifu - self-checking bench for the instruction fetch unit.
// A memory model answers granted fetches in order after 1..3 cycles with a
// data word derived from the address. The reference model only tracks the
// next address to be fetched and the next address to be consumed, both
// restarting at the aligned target on a redirect.
`timescale 1ns/1ps
module tb_ifu;

`ifdef IFU_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        jump_en = 1'b0;
  logic [31:0] jump_addr = 32'h0;
  logic        hold = 1'b0;
  logic        rom_gnt = 1'b0;
  logic        rom_rvalid = 1'b0;
  logic [31:0] rom_rdata = 32'h0;
  logic        rom_req;
  logic [31:0] rom_addr;
  logic [31:0] inst;
  logic [31:0] inst_addr;
  logic        inst_valid;
  logic        misalign;

  ifu dut (
    .clk          (clk),
    .rst          (rst),
    .jump_en_i    (jump_en),
    .jump_addr_i  (jump_addr),
    .hold_i       (hold),
    .rom_req_o    (rom_req),
    .rom_addr_o   (rom_addr),
    .rom_gnt_i    (rom_gnt),
    .rom_rvalid_i (rom_rvalid),
    .rom_rdata_i  (rom_rdata),
    .inst_o       (inst),
    .inst_addr_o  (inst_addr),
    .inst_valid_o (inst_valid),
    .misalign_o   (misalign)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] addr;
    int          due;
  } mreq_t;

  mreq_t       mq[$];
  int          cyc;
  int          lat;
  int          last_due;
  int          checks = 0;
  int          passed = 0;

  logic        s_req, s_valid, s_mis, granted, popped;
  logic [31:0] s_addr, s_inst, s_iaddr;
  logic [31:0] exp_fetch, exp_cons, pre_fetch, pre_cons;
  logic [31:0] cons_log[$];
  logic [31:0] cons_inst[$];

  function automatic logic [31:0] fdata(input logic [31:0] a);
    return 32'h0010_0093 ^ (a << 8);
  endfunction

  task automatic init_model();
    cyc = 0; lat = 1; last_due = -1;
    exp_fetch = 32'h0; exp_cons = 32'h0;
    cons_log.delete(); cons_inst.delete();
  endtask

  // One clock cycle: present memory response, sample, then advance models.
  task automatic tick();
    int d;
    if (mq.size() > 0 && mq[0].due <= cyc) begin
      rom_rvalid = 1'b1; rom_rdata = fdata(mq[0].addr);
    end else begin
      rom_rvalid = 1'b0; rom_rdata = $urandom;
    end
    @(negedge clk);
    s_req = rom_req; s_addr = rom_addr; s_valid = inst_valid;
    s_inst = inst; s_iaddr = inst_addr; s_mis = misalign;
    granted = s_req && rom_gnt;
    popped = s_valid && !hold && !jump_en;
    pre_fetch = exp_fetch; pre_cons = exp_cons;
    if (popped) begin
      cons_log.push_back(s_iaddr); cons_inst.push_back(s_inst);
    end
    @(posedge clk);
    if (rom_rvalid) mq.delete(0);
    if (granted) begin
      d = cyc + lat;
      if (d <= last_due) d = last_due + 1;
      mq.push_back('{addr: s_addr, due: d});
      last_due = d;
    end
    if (jump_en) begin
      exp_fetch = {jump_addr[31:2], 2'b00}; exp_cons = exp_fetch;
    end else begin
      if (granted) exp_fetch = exp_fetch + 32'd4;
      if (popped) exp_cons = exp_cons + 32'd4;
    end
    cyc++;
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0; jump_en = 1'b0; hold = 1'b0; rom_gnt = 1'b0; rom_rvalid = 1'b0; jump_addr = 32'h0;
    mq.delete(); init_model();
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  task automatic run_until_cons(input int n, input int budget);
    for (int i = 0; i < budget && cons_log.size() < n; i++) tick();
  endtask

  task automatic test_reset();
    rst = 1'b0; rom_gnt = 1'b0; rom_rvalid = 1'b0; mq.delete();
    repeat (2) @(negedge clk);
    checks++; if (rom_req !== 1'b0) $display("FAIL reset_req: got %b want 0", rom_req); else passed++;
    checks++; if (inst_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", inst_valid); else passed++;
    checks++; if (inst !== NOP) $display("FAIL reset_inst: got %h want %h", inst, NOP); else passed++;
    checks++; if (inst_addr !== 32'h0) $display("FAIL reset_iaddr: got %h want 0", inst_addr); else passed++;
    checks++; if (rom_addr !== 32'h0) $display("FAIL reset_pc: got %h want 0", rom_addr); else passed++;
    checks++; if (misalign !== 1'b0) $display("FAIL reset_mis: got %b want 0", misalign); else passed++;
    @(posedge clk); #1 rst = 1'b1; init_model();
    tick();
    checks++; if (s_req !== 1'b1 || s_addr !== 32'h0) $display("FAIL reset_first_req: got req=%b addr=%h want 1/0", s_req, s_addr); else passed++;
    $display("test_reset: done, %0d/%0d so far", passed, checks);
  endtask

  task automatic test_basic();
    do_reset(); rom_gnt = 1'b1; lat = 1;
    tick();
    checks++; if (s_req !== 1'b1 || s_addr !== 32'h0) $display("FAIL basic_req0: got req=%b addr=%h want 1/0", s_req, s_addr); else passed++;
    tick();
    checks++; if (s_valid !== 1'b0) $display("FAIL basic_no_bypass: got valid=%b want 0", s_valid); else passed++;
    tick();
    checks++; if (s_valid !== 1'b1 || s_inst !== 32'h0010_0093 || s_iaddr !== 32'h0)
      $display("FAIL basic_first_inst: got v=%b inst=%h addr=%h want 1/00100093/0", s_valid, s_inst, s_iaddr); else passed++;
    run_until_cons(3, 20);
    checks++;
    if (cons_log.size() < 3) $display("FAIL basic_seq_timeout: got %0d instrs want 3", cons_log.size());
    else if (cons_log[1] !== 32'h4 || cons_log[2] !== 32'h8 || cons_inst[2] !== fdata(32'h8))
      $display("FAIL basic_seq: got %h,%h inst %h want 4,8 inst %h", cons_log[1], cons_log[2], cons_inst[2], fdata(32'h8));
    else passed++;
    $display("test_basic: done, %0d/%0d so far", passed, checks);
  endtask

  task automatic test_hold();
    logic [31:0] held_i, held_a;
    int grants, n0;
    do_reset(); rom_gnt = 1'b1; lat = 1;
    for (int i = 0; i < 10 && !inst_valid; i++) tick();
    held_i = inst; held_a = inst_addr; grants = 0;
    hold = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      if (granted) grants++;
      checks++; if (s_valid !== 1'b1 || s_inst !== held_i || s_iaddr !== held_a)
        $display("FAIL hold_frozen[%0d]: got v=%b %h@%h want 1 %h@%h", k, s_valid, s_inst, s_iaddr, held_i, held_a); else passed++;
    end
    checks++; if (s_req !== 1'b0 || grants > 2) $display("FAIL hold_credit: got req=%b grants=%0d want 0/<=2", s_req, grants); else passed++;
    hold = 1'b0; n0 = cons_log.size();
    run_until_cons(n0 + 3, 30);
    checks++;
    if (cons_log.size() < n0 + 3) $display("FAIL hold_resume_timeout: got %0d want %0d", cons_log.size(), n0 + 3);
    else if (cons_log[n0] !== held_a || cons_log[n0+1] !== held_a + 32'd4 || cons_log[n0+2] !== held_a + 32'd8 || cons_inst[n0] !== held_i)
      $display("FAIL hold_resume: got %h,%h,%h want %h,+4,+8", cons_log[n0], cons_log[n0+1], cons_log[n0+2], held_a);
    else passed++;
    $display("test_hold: done, %0d/%0d so far", passed, checks);
  endtask

  task automatic test_jump_outstanding();
    do_reset(); rom_gnt = 1'b1; lat = 3;
    tick(); tick();
    jump_en = 1'b1; jump_addr = 32'h0000_0100;
    tick();
    checks++; if (s_req !== 1'b0) $display("FAIL jump_req_masked: got %b want 0", s_req); else passed++;
    jump_en = 1'b0;
    tick();
    checks++; if (s_valid !== 1'b0) $display("FAIL jump_flush: got valid=%b want 0", s_valid); else passed++;
    run_until_cons(2, 30);
    checks++;
    if (cons_log.size() < 2) $display("FAIL jump_out_timeout: got %0d want 2", cons_log.size());
    else if (cons_log[0] !== 32'h100 || cons_inst[0] !== fdata(32'h100) || cons_log[1] !== 32'h104)
      $display("FAIL jump_out: got %h(%h),%h want 100(%h),104", cons_log[0], cons_inst[0], cons_log[1], fdata(32'h100));
    else passed++;
    $display("test_jump_outstanding: done, %0d/%0d so far", passed, checks);
  endtask

  task automatic test_jump_rvalid();
    bit seen_old;
    do_reset(); rom_gnt = 1'b1; lat = 1;
    tick();
    jump_en = 1'b1; jump_addr = 32'h0000_0200;
    tick();
    jump_en = 1'b0;
    run_until_cons(3, 30);
    seen_old = 1'b0;
    foreach (cons_inst[i]) if (cons_inst[i] === fdata(32'h0)) seen_old = 1'b1;
    checks++; if (seen_old) $display("FAIL jump_rvalid_drop: got stale inst %h want none", fdata(32'h0)); else passed++;
    checks++;
    if (cons_log.size() < 3) $display("FAIL jump_rvalid_timeout: got %0d want 3", cons_log.size());
    else if (cons_log[0] !== 32'h200 || cons_inst[0] !== fdata(32'h200))
      $display("FAIL jump_rvalid_first: got %h@%h want %h@200", cons_inst[0], cons_log[0], fdata(32'h200));
    else passed++;
    $display("test_jump_rvalid: done, %0d/%0d so far", passed, checks);
  endtask

  task automatic test_wrap();
    do_reset(); rom_gnt = 1'b1; lat = 1;
    jump_en = 1'b1; jump_addr = 32'hFFFF_FFFC;
    tick();
    jump_en = 1'b0;
    tick();
    checks++; if (s_req !== 1'b1 || s_addr !== 32'hFFFF_FFFC) $display("FAIL wrap_top: got req=%b addr=%h want 1/fffffffc", s_req, s_addr); else passed++;
    tick();
    checks++; if (s_req !== 1'b1 || s_addr !== 32'h0) $display("FAIL wrap_zero: got req=%b addr=%h want 1/0", s_req, s_addr); else passed++;
    run_until_cons(2, 20);
    checks++;
    if (cons_log.size() < 2) $display("FAIL wrap_timeout: got %0d want 2", cons_log.size());
    else if (cons_log[0] !== 32'hFFFF_FFFC || cons_log[1] !== 32'h0)
      $display("FAIL wrap_stream: got %h,%h want fffffffc,0", cons_log[0], cons_log[1]);
    else passed++;
    $display("test_wrap: done, %0d/%0d so far", passed, checks);
  endtask

  task automatic test_misalign();
    do_reset(); rom_gnt = 1'b1; lat = 1;
    tick(); tick();
    jump_en = 1'b1; jump_addr = 32'h0000_0102;
    tick();
    checks++; if (s_mis !== 1'b0) $display("FAIL mis_early: got %b want 0", s_mis); else passed++;
    jump_en = 1'b0;
    tick();
    checks++; if (s_mis !== TRAP) $display("FAIL mis_pulse: got %b want %b", s_mis, TRAP); else passed++;
    checks++; if (s_addr !== 32'h100) $display("FAIL mis_pc: got %h want 100", s_addr); else passed++;
    tick();
    checks++; if (s_mis !== 1'b0) $display("FAIL mis_one_cycle: got %b want 0", s_mis); else passed++;
    run_until_cons(1, 20);
    checks++;
    if (cons_log.size() < 1) $display("FAIL mis_timeout: got 0 instrs want 1");
    else if (cons_log[0] !== 32'h100) $display("FAIL mis_stream: got %h want 100", cons_log[0]);
    else passed++;
    $display("test_misalign: done, %0d/%0d so far", passed, checks);
  endtask

  task automatic test_reset_midflight();
    do_reset(); rom_gnt = 1'b1; lat = 3;
    tick(); tick();
    rst = 1'b0; rom_gnt = 1'b0; rom_rvalid = 1'b0;
    #2;
    checks++; if (rom_req !== 1'b0 || inst_valid !== 1'b0) $display("FAIL midreset_outputs: got req=%b valid=%b want 0/0", rom_req, inst_valid); else passed++;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    exp_fetch = 32'h0; exp_cons = 32'h0; cons_log.delete(); cons_inst.delete();
    for (int k = 0; k < 5; k++) begin
      tick();
      checks++; if (s_valid !== 1'b0) $display("FAIL midreset_ignore[%0d]: got valid=%b inst=%h want 0", k, s_valid, s_inst); else passed++;
    end
    rom_gnt = 1'b1; lat = 1;
    run_until_cons(2, 20);
    checks++;
    if (cons_log.size() < 2) $display("FAIL midreset_timeout: got %0d want 2", cons_log.size());
    else if (cons_log[0] !== 32'h0 || cons_inst[0] !== fdata(32'h0) || cons_log[1] !== 32'h4)
      $display("FAIL midreset_restart: got %h(%h),%h want 0(%h),4", cons_log[0], cons_inst[0], cons_log[1], fdata(32'h0));
    else passed++;
    $display("test_reset_midflight: done, %0d/%0d so far", passed, checks);
  endtask

  task automatic test_random();
    bit exp_mis, prev_frozen;
    logic [31:0] prev_inst, prev_iaddr;
    int c0;
    do_reset();
    exp_mis = 1'b0; prev_frozen = 1'b0; prev_inst = 32'h0; prev_iaddr = 32'h0;
    c0 = checks;
    for (int n = 0; n < 800; n++) begin
      rom_gnt = ($urandom_range(0, 3) != 0);
      hold    = ($urandom_range(0, 3) == 0);
      jump_en = ($urandom_range(0, 39) == 0);
      jump_addr = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
      lat = $urandom_range(1, 3);
      tick();
      if (granted) begin
        checks++; if (s_addr !== pre_fetch) $display("FAIL rnd_fetch_addr cyc%0d: got %h want %h", cyc, s_addr, pre_fetch); else passed++;
      end
      if (popped) begin
        checks++; if (s_iaddr !== pre_cons || s_inst !== fdata(pre_cons))
          $display("FAIL rnd_consume cyc%0d: got %h@%h want %h@%h", cyc, s_inst, s_iaddr, fdata(pre_cons), pre_cons); else passed++;
      end
      if (!s_valid) begin
        checks++; if (s_inst !== NOP) $display("FAIL rnd_nop cyc%0d: got %h want %h", cyc, s_inst, NOP); else passed++;
      end
      if (prev_frozen) begin
        checks++; if (s_valid !== 1'b1 || s_inst !== prev_inst || s_iaddr !== prev_iaddr)
          $display("FAIL rnd_hold cyc%0d: got %b %h@%h want 1 %h@%h", cyc, s_valid, s_inst, s_iaddr, prev_inst, prev_iaddr); else passed++;
      end
      checks++; if ((pre_fetch - pre_cons) > 32'd8) $display("FAIL rnd_credit cyc%0d: got %0d ahead want <=8", cyc, pre_fetch - pre_cons); else passed++;
      checks++; if (s_mis !== (TRAP && exp_mis)) $display("FAIL rnd_misalign cyc%0d: got %b want %b", cyc, s_mis, TRAP && exp_mis); else passed++;
      prev_frozen = s_valid && hold && !jump_en;
      prev_inst = s_inst; prev_iaddr = s_iaddr;
      exp_mis = jump_en && (jump_addr[1:0] != 2'b00);
    end
    jump_en = 1'b0; hold = 1'b0;
    checks++; if (cons_log.size() < 50) $display("FAIL rnd_progress: got %0d instrs want >=50", cons_log.size()); else passed++;
    $display("test_random: %0d checks, %0d instrs consumed", checks - c0, cons_log.size());
  endtask

  initial begin
    test_reset();
    test_basic();
    test_hold();
    test_jump_outstanding();
    test_jump_rvalid();
    test_wrap();
    test_misalign();
    test_reset_midflight();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", passed, checks);
    $fatal(1, "watchdog");
  end

endmodule
